// File: rtl/loader_pkg.sv
// Shared types for the UART boot loader.
// Framing FSM states, receiver states and the default sync marker.
`timescale 1ns/1ps
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with start-bit glitch rejection.
// Emits one-cycle byte_valid or frame_err per received character.
`timescale 1ns/1ps
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;

  rx_state_t   st;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_d;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= RX_IDLE;
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_d         <= 1'b1;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      byte_valid_o <= 1'b0;
      byte_data_o  <= '0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_s1        <= rx_i;
      rx_s2        <= rx_s1;
      rx_d         <= rx_s2;
      byte_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      unique case (st)
        RX_IDLE: begin
          if (rx_d && !rx_s2) begin
            st  <= RX_START;
            cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt == 32'(HALF - 1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            // Line back high at mid-start: treat as glitch
            st      <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + 1;
          end
        end
        RX_DATA: begin
          if (cnt == 32'(DIV - 1)) begin
            cnt     <= '0;
            shreg   <= {rx_s2, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7)
              st <= RX_STOP;
          end else begin
            cnt <= cnt + 1;
          end
        end
        RX_STOP: begin
          if (cnt == 32'(DIV - 1)) begin
            cnt <= '0;
            st  <= RX_IDLE;
            if (rx_s2) begin
              byte_valid_o <= 1'b1;
              byte_data_o  <= shreg;
            end else begin
              frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rom_loader.sv
// UART boot loader: framed image -> ROM write port.
// Holds the CPU in reset until a checksum-verified image is loaded.
`timescale 1ns/1ps
module uart_rom_loader
  import loader_pkg::*;
#(
  parameter int         CLK_FREQ       = 50000000,
  parameter int         BAUD           = 115200,
  parameter int         ADDR_WIDTH     = 12,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 5000000,
  parameter int         HOLD_AT_RESET  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx_i,
  input  logic        load_req_i,
  output logic        rom_we_o,
  output logic [31:0] rom_waddr_o,
  output logic [31:0] rom_wdata_o,
  output logic        cpu_rst_n_o,
  output logic        busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

  state_t      state;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_err;
  logic [1:0]  bcnt;
  logic [31:0] len;
  logic [31:0] word;
  logic [31:0] widx;
  logic [31:0] tmo;
  logic [7:0]  sum;
  logic [31:0] len_nxt;
  logic [31:0] word_nxt;
  logic        active;
  logic        abort;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx_i),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  assign len_nxt  = {byte_data, len[31:8]};
  assign word_nxt = {byte_data, word[31:8]};
  assign active   = (state == LEN) || (state == DATA) || (state == CSUM);
  // A byte arriving on the expiry cycle wins over the timeout
  assign abort    = active && (frame_err ||
                    (!byte_valid && tmo == 32'(TIMEOUT_CYCLES - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bcnt        <= '0;
      len         <= '0;
      word        <= '0;
      widx        <= '0;
      tmo         <= '0;
      sum         <= '0;
      rom_we_o    <= 1'b0;
      rom_waddr_o <= '0;
      rom_wdata_o <= '0;
      cpu_rst_n_o <= (HOLD_AT_RESET == 0);
      busy_o      <= 1'b0;
      load_done_o <= 1'b0;
      load_err_o  <= 1'b0;
    end else begin
      rom_we_o <= 1'b0;
      if (active && !byte_valid)
        tmo <= tmo + 1;
      else
        tmo <= '0;
      if (abort) begin
        state      <= ERR;
        load_err_o <= 1'b1;
        busy_o     <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE, ERR: begin
            if (load_req_i) begin
              state       <= SYNC;
              cpu_rst_n_o <= 1'b0;
              load_done_o <= 1'b0;
              load_err_o  <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          SYNC: begin
            if (byte_valid && byte_data == SYNC_BYTE) begin
              state <= LEN;
              bcnt  <= '0;
              widx  <= '0;
              sum   <= '0;
            end
          end
          LEN: begin
            if (byte_valid) begin
              len  <= len_nxt;
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                if ({1'b0, len_nxt} > DEPTH) begin
                  state      <= ERR;
                  load_err_o <= 1'b1;
                  busy_o     <= 1'b0;
                end else if (len_nxt == '0) begin
                  state <= CSUM;
                end else begin
                  state <= DATA;
                end
              end
            end
          end
          DATA: begin
            if (byte_valid) begin
              sum  <= sum + byte_data;
              word <= word_nxt;
              bcnt <= bcnt + 2'd1;
              if (bcnt == 2'd3) begin
                rom_we_o    <= 1'b1;
                rom_waddr_o <= widx << 2;
                rom_wdata_o <= word_nxt;
                widx        <= widx + 1;
                if (widx == len - 1)
                  state <= CSUM;
              end
            end
          end
          CSUM: begin
            if (byte_valid) begin
              busy_o <= 1'b0;
              if (byte_data == sum) begin
                state       <= DONE;
                load_done_o <= 1'b1;
                cpu_rst_n_o <= 1'b1;
              end else begin
                state      <= ERR;
                load_err_o <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rom_loader.sv
// Directed bench for uart_rom_loader with a 40-clock bit period,
// a 4-word ROM and a 3000-clock inter-byte timeout.
`timescale 1ns/1ps
module tb_uart_rom_loader;

  localparam int DIV = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic        load_req_i = 1'b0;
  logic        rom_we_o;
  logic [31:0] rom_waddr_o;
  logic [31:0] rom_wdata_o;
  logic        cpu_rst_n_o;
  logic        busy_o;
  logic        load_done_o;
  logic        load_err_o;

  int checks = 0;
  int errs = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always #5 clk = ~clk;

  uart_rom_loader #(
    .CLK_FREQ       (4000000),
    .BAUD           (100000),
    .ADDR_WIDTH     (2),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (3000),
    .HOLD_AT_RESET  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_rx_i   (uart_rx_i),
    .load_req_i  (load_req_i),
    .rom_we_o    (rom_we_o),
    .rom_waddr_o (rom_waddr_o),
    .rom_wdata_o (rom_wdata_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .busy_o      (busy_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always @(negedge clk) begin
    if (rom_we_o) begin
      wa.push_back(rom_waddr_o);
      wd.push_back(rom_wdata_o);
    end
  end

  task automatic send_bit(input logic b);
    uart_rx_i = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx_i = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_raw(b, 1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    load_req_i = 1'b1;
    @(negedge clk);
    load_req_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (5) @(negedge clk);
    checks++;
    if ({rom_we_o, rom_waddr_o, rom_wdata_o, cpu_rst_n_o, busy_o,
         load_done_o, load_err_o} !== 69'd0) begin
      errs++;
      $display("FAIL rst_hold got=%h exp=0", {rom_we_o, rom_waddr_o,
               rom_wdata_o, cpu_rst_n_o, busy_o, load_done_o, load_err_o});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    wa.delete(); wd.delete();
    send_byte(8'hA5);
    send_word(32'h1);
    checks++;
    if ({cpu_rst_n_o, busy_o, load_done_o, load_err_o, wa.size() == 0}
        !== 5'b00001) begin
      errs++;
      $display("FAIL idle_drop got=%b%b%b%b n=%0d exp=0000 n=0",
               cpu_rst_n_o, busy_o, load_done_o, load_err_o, wa.size());
    end
  endtask

  task automatic test_good();
    logic [63:0] ew [2];
    ew = '{{32'h0, 32'h13}, {32'h4, 32'h6F}};
    wa.delete(); wd.delete();
    pulse_req();
    checks++;
    if ({busy_o, cpu_rst_n_o} !== 2'b10) begin
      errs++;
      $display("FAIL good_start got=%b%b exp=10", busy_o, cpu_rst_n_o);
    end
    send_byte(8'hA5);
    send_word(32'd2);
    send_word(32'h13);
    send_word(32'h6F);
    send_byte(8'h82);
    checks++;
    if (wa.size() != 2) begin
      errs++;
      $display("FAIL good_nwr got=%0d exp=2", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 2; i++) begin
      checks++;
      if ({wa[i], wd[i]} !== ew[i]) begin
        errs++;
        $display("FAIL good_wr%0d got=%h exp=%h", i, {wa[i], wd[i]}, ew[i]);
      end
    end
    checks++;
    if ({load_done_o, cpu_rst_n_o, load_err_o, busy_o} !== 4'b1100) begin
      errs++;
      $display("FAIL good_status got=%b%b%b%b exp=1100",
               load_done_o, cpu_rst_n_o, load_err_o, busy_o);
    end
  endtask

  task automatic test_busy_req();
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    pulse_req();
    send_word(32'd2);
    send_word(32'h13);
    pulse_req();
    send_word(32'h6F);
    send_byte(8'h82);
    checks++;
    if ({load_done_o, wa.size() == 2} !== 2'b11) begin
      errs++;
      $display("FAIL busy_req got=done%b n=%0d exp=done1 n=2",
               load_done_o, wa.size());
    end
  endtask

  task automatic test_bad_csum();
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    send_word(32'd2);
    send_word(32'h13);
    send_word(32'h6F);
    send_byte(8'h83);
    checks++;
    if (wa.size() != 2 || wd[0] !== 32'h13 || wd[1] !== 32'h6F) begin
      errs++;
      $display("FAIL bad_wr got=n%0d exp=n2 13/6F", wa.size());
    end
    checks++;
    if ({load_err_o, cpu_rst_n_o, load_done_o, busy_o} !== 4'b1000) begin
      errs++;
      $display("FAIL bad_status got=%b%b%b%b exp=1000",
               load_err_o, cpu_rst_n_o, load_done_o, busy_o);
    end
    send_byte(8'hA5);
    send_byte(8'h00);
    checks++;
    if ({load_err_o, busy_o, wa.size() == 2} !== 3'b101) begin
      errs++;
      $display("FAIL err_drop got=%b%b n=%0d exp=10 n=2",
               load_err_o, busy_o, wa.size());
    end
  endtask

  task automatic test_noise();
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    checks++;
    if (busy_o !== 1'b1) begin
      errs++;
      $display("FAIL noise_busy got=%b exp=1", busy_o);
    end
    send_byte(8'hA5);
    send_word(32'd0);
    send_byte(8'h00);
    checks++;
    if ({load_done_o, load_err_o, cpu_rst_n_o, wa.size() == 0} !== 4'b1011)
    begin
      errs++;
      $display("FAIL noise_done got=%b%b%b n=%0d exp=101 n=0",
               load_done_o, load_err_o, cpu_rst_n_o, wa.size());
    end
  endtask

  task automatic test_len_over();
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    send_word(32'd5);
    checks++;
    if ({load_err_o, busy_o, wa.size() == 0} !== 3'b101) begin
      errs++;
      $display("FAIL len5 got=%b%b n=%0d exp=10 n=0",
               load_err_o, busy_o, wa.size());
    end
    pulse_req();
    send_byte(8'hA5);
    send_word(32'h00001001);
    checks++;
    if ({load_err_o, busy_o, wa.size() == 0} !== 3'b101) begin
      errs++;
      $display("FAIL len1001 got=%b%b n=%0d exp=10 n=0",
               load_err_o, busy_o, wa.size());
    end
  endtask

  task automatic test_len_max();
    logic [31:0] w [4];
    w = '{32'h04030201, 32'h40302010, 32'h000000FF, 32'hDDCCBBAA};
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(w[i]);
    send_byte(8'hB7);
    checks++;
    if (wa.size() != 4) begin
      errs++;
      $display("FAIL max_nwr got=%0d exp=4", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 4; i++) begin
      checks++;
      if (wa[i] !== 32'(4 * i) || wd[i] !== w[i]) begin
        errs++;
        $display("FAIL max_wr%0d got=%h/%h exp=%h/%h",
                 i, wa[i], wd[i], 32'(4 * i), w[i]);
      end
    end
    checks++;
    if ({load_done_o, load_err_o} !== 2'b10) begin
      errs++;
      $display("FAIL max_done got=%b%b exp=10", load_done_o, load_err_o);
    end
  endtask

  task automatic test_frame_err();
    pulse_req();
    send_byte(8'hA5);
    send_raw(8'h02, 1'b0);
    repeat (DIV) @(negedge clk);
    checks++;
    if ({load_err_o, busy_o} !== 2'b10) begin
      errs++;
      $display("FAIL frame_err got=%b%b exp=10", load_err_o, busy_o);
    end
  endtask

  task automatic test_timeout();
    int n;
    pulse_req();
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (2500) @(negedge clk);
    checks++;
    if ({load_err_o, busy_o} !== 2'b01) begin
      errs++;
      $display("FAIL tmo_early got=%b%b exp=01", load_err_o, busy_o);
    end
    n = 0;
    while (!load_err_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({load_err_o, busy_o, cpu_rst_n_o} !== 3'b100) begin
      errs++;
      $display("FAIL tmo_err got=%b%b%b exp=100",
               load_err_o, busy_o, cpu_rst_n_o);
    end
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    send_word(32'd2);
    send_word(32'h13);
    send_word(32'h6F);
    send_byte(8'h82);
    checks++;
    if ({load_done_o, load_err_o, wa.size() == 2} !== 3'b101) begin
      errs++;
      $display("FAIL tmo_reload got=%b%b n=%0d exp=10 n=2",
               load_done_o, load_err_o, wa.size());
    end
  endtask

  task automatic test_glitch_reset();
    wa.delete(); wd.delete();
    pulse_req();
    send_byte(8'hA5);
    send_word(32'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    uart_rx_i = 1'b0;
    repeat (10) @(negedge clk);
    uart_rx_i = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    send_byte(8'h33);
    send_byte(8'h44);
    checks++;
    if (wa.size() != 1 || wd[0] !== 32'h44332211 || wa[0] !== 32'h0) begin
      errs++;
      $display("FAIL glitch_wr got=n%0d exp=n1 0/44332211", wa.size());
    end
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rom_we_o, rom_waddr_o, rom_wdata_o, cpu_rst_n_o, busy_o,
         load_done_o, load_err_o} !== 69'd0) begin
      errs++;
      $display("FAIL mid_rst got=%h exp=0", {rom_we_o, rom_waddr_o,
               rom_wdata_o, cpu_rst_n_o, busy_o, load_done_o, load_err_o});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h77);
    send_byte(8'h88);
    checks++;
    if ({busy_o, cpu_rst_n_o, wa.size() == 1} !== 3'b001) begin
      errs++;
      $display("FAIL post_rst got=%b%b n=%0d exp=00 n=1",
               busy_o, cpu_rst_n_o, wa.size());
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_busy_req();
    test_bad_csum();
    test_noise();
    test_len_over();
    test_len_max();
    test_frame_err();
    test_timeout();
    test_glitch_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule
